pipelined_adder: RTL and testbench

- Parametrised, pipelined carry-chunked adder/subtractor with valid/ready handshakes on input and output.
- Splits WIDTH into STAGES equal chunks. Each pipeline stage adds one chunk and registers the carry into the next stage.
- Sustains one operation per clock at high WIDTH and Fmax.
- Drop-in replacement for the combinational adders wherever a registered, flow-controlled datapath is needed.

---
 rtl/pipelined_adder_if.sv | 27 ++
 rtl/pipelined_adder.sv | 133 +++++++++++++
 tb/tb_pipelined_adder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// Handshake bundle for the pipelined adder/subtractor.
// Master drives operands and out_ready; slave returns results.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Carry-chunked adder/subtractor, one CW-bit chunk per stage,
// with valid/ready flow control and collapsing bubbles.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int SUB_EN = 1
) (
    input logic              clk,
    input logic              rst,
    pipelined_adder_if.slave bus
);
    localparam int SN = (STAGES < 1) ? 1 : STAGES;
    localparam int CW = WIDTH / SN;

    if ((STAGES < 1) || (WIDTH % SN != 0)) begin : g_bad_cfg
        $error("pipelined_adder: STAGES must be >=1 and divide WIDTH");
    end

    logic [WIDTH-1:0] a_r [SN];
    logic [WIDTH-1:0] b_r [SN];
    logic [WIDTH-1:0] s_r [SN];
    logic [WIDTH-1:0] a_i [SN];
    logic [WIDTH-1:0] b_i [SN];
    logic [WIDTH-1:0] s_i [SN];
    logic [WIDTH-1:0] s_n [SN];
    logic [CW:0]      sum [SN];
    logic [SN-1:0]    v_r;
    logic [SN-1:0]    v_i;
    logic [SN-1:0]    c_r;
    logic [SN-1:0]    c_i;
    logic [SN-1:0]    c_n;
    logic [SN:0]      go;
    logic [WIDTH-1:0] b_e;
    logic             sub_e;
    logic             c0;
    logic             init_q;
    logic             ovf_r;
    logic             ovf_n;
    logic             unused_x;

    assign sub_e = (SUB_EN != 0) && bus.sub;
    assign b_e   = sub_e ? ~bus.b : bus.b;
    assign c0    = sub_e ? 1'b1 : bus.cin;

    // Stage k may load when empty or when its content moves on.
    always_comb begin
        go     = '0;
        go[SN] = bus.out_ready;
        for (int k = SN - 1; k >= 0; k--) begin
            go[k] = !v_r[k] || go[k+1];
        end
    end

    assign bus.in_ready  = go[0] && init_q;
    assign bus.out_valid = v_r[SN-1];
    assign bus.s         = s_r[SN-1];
    assign bus.cout      = c_r[SN-1];
    assign bus.ovf       = ovf_r;

    // Per-stage chunk add: stage k adds bits [k*CW +: CW].
    always_comb begin
        a_i   = '{default: '0};
        b_i   = '{default: '0};
        s_i   = '{default: '0};
        s_n   = '{default: '0};
        sum   = '{default: '0};
        v_i   = '0;
        c_i   = '0;
        c_n   = '0;
        for (int k = 0; k < SN; k++) begin
            int j;
            j = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                a_i[k] = bus.a;
                b_i[k] = b_e;
                s_i[k] = '0;
                c_i[k] = c0;
                v_i[k] = bus.in_valid && init_q;
            end else begin
                a_i[k] = a_r[j];
                b_i[k] = b_r[j];
                s_i[k] = s_r[j];
                c_i[k] = c_r[j];
                v_i[k] = v_r[j];
            end
            sum[k] = {1'b0, a_i[k][k*CW +: CW]}
                   + {1'b0, b_i[k][k*CW +: CW]}
                   + {{CW{1'b0}}, c_i[k]};
            s_n[k] = s_i[k];
            s_n[k][k*CW +: CW] = sum[k][CW-1:0];
            c_n[k] = sum[k][CW];
        end
        ovf_n = (a_i[SN-1][WIDTH-1] == b_i[SN-1][WIDTH-1])
             && (s_n[SN-1][WIDTH-1] != a_i[SN-1][WIDTH-1]);
    end

    // Operand bits already consumed are simply dropped downstream.
    always_comb begin
        unused_x = 1'b0;
        for (int k = 0; k < SN; k++) begin
            unused_x = unused_x ^ (^a_r[k]) ^ (^b_r[k]);
        end
    end

    // Pipeline registers; reset clears valids and all data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q <= 1'b0;
            ovf_r  <= 1'b0;
            v_r    <= '0;
            c_r    <= '0;
            for (int k = 0; k < SN; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
        end else begin
            init_q <= 1'b1;
            for (int k = 0; k < SN; k++) begin
                if (go[k]) begin
                    v_r[k] <= v_i[k];
                    a_r[k] <= a_i[k];
                    b_r[k] <= b_i[k];
                    s_r[k] <= s_n[k];
                    c_r[k] <= c_n[k];
                end
            end
            if (go[SN-1]) begin
                ovf_r <= ovf_n;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at STAGES = 4, 1 and 32.
// Shared stimulus; each DUT has its own expected-result queue.
module tb_pipelined_adder;
    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic [31:0] ta;
    logic [31:0] tbv;
    logic        tcin;
    logic        tsub;
    logic        ord4;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(32)) i4 ();
    pipelined_adder_if #(.WIDTH(32)) i1 ();
    pipelined_adder_if #(.WIDTH(32)) i32 ();

    assign i4.in_valid   = iv;
    assign i4.a          = ta;
    assign i4.b          = tbv;
    assign i4.cin        = tcin;
    assign i4.sub        = tsub;
    assign i4.out_ready  = ord4;
    assign i1.in_valid   = iv;
    assign i1.a          = ta;
    assign i1.b          = tbv;
    assign i1.cin        = tcin;
    assign i1.sub        = tsub;
    assign i1.out_ready  = 1'b1;
    assign i32.in_valid  = iv;
    assign i32.a         = ta;
    assign i32.b         = tbv;
    assign i32.cin       = tcin;
    assign i32.sub       = tsub;
    assign i32.out_ready = 1'b1;

    pipelined_adder #(.WIDTH(32), .STAGES(4), .SUB_EN(1)) u4 (
        .clk(clk), .rst(rst), .bus(i4.slave)
    );
    pipelined_adder #(.WIDTH(32), .STAGES(1), .SUB_EN(1)) u1 (
        .clk(clk), .rst(rst), .bus(i1.slave)
    );
    pipelined_adder #(.WIDTH(32), .STAGES(32), .SUB_EN(1)) u32 (
        .clk(clk), .rst(rst), .bus(i32.slave)
    );

    logic        ir [3];
    logic        ov [3];
    logic        orr [3];
    logic        cy [3];
    logic        of [3];
    logic [31:0] sv [3];

    assign ir[0]  = i4.in_ready;
    assign ir[1]  = i1.in_ready;
    assign ir[2]  = i32.in_ready;
    assign ov[0]  = i4.out_valid;
    assign ov[1]  = i1.out_valid;
    assign ov[2]  = i32.out_valid;
    assign orr[0] = i4.out_ready;
    assign orr[1] = i1.out_ready;
    assign orr[2] = i32.out_ready;
    assign cy[0]  = i4.cout;
    assign cy[1]  = i1.cout;
    assign cy[2]  = i32.cout;
    assign of[0]  = i4.ovf;
    assign of[1]  = i1.ovf;
    assign of[2]  = i32.ovf;
    assign sv[0]  = i4.s;
    assign sv[1]  = i1.s;
    assign sv[2]  = i32.s;

    exp_t q [3][$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc [3] = '{0, 0, 0};
    int   lat [3] = '{4, 1, 32};
    logic chk_lat = 1'b1;
    logic use_k   = 1'b0;
    exp_t kexp;

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic sb);
        exp_t        e;
        logic [32:0] w;
        longint      r;
        w = {1'b0, a} + {1'b0, b} + {32'd0, c};
        if (sb) begin
            e.s = a - b;
            e.c = (a >= b);
            r   = longint'($signed(a)) - longint'($signed(b));
        end else begin
            e.s = w[31:0];
            e.c = w[32];
            r   = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        end
        e.o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.cyc = 0;
        return e;
    endfunction

    task automatic chk(input string n, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, got, want);
        end
    endtask

    // Monitor: transfers are evaluated at the negedge before the edge.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                q[d].delete();
                continue;
            end
            if (ov[d] && orr[d]) begin
                total++;
                if (q[d].size() == 0) begin
                    bad++;
                    $display("FAIL spurious dut%0d s=%h", d, sv[d]);
                end else begin
                    e = q[d].pop_front();
                    if ({sv[d], cy[d], of[d]} !== {e.s, e.c, e.o}) begin
                        bad++;
                        $display("FAIL result dut%0d got s=%h c=%b o=%b want s=%h c=%b o=%b",
                                 d, sv[d], cy[d], of[d], e.s, e.c, e.o);
                    end
                    if (chk_lat) begin
                        total++;
                        if (cyc - e.cyc != lat[d]) begin
                            bad++;
                            $display("FAIL latency dut%0d got=%0d want=%0d",
                                     d, cyc - e.cyc, lat[d]);
                        end
                    end
                end
            end
            if (iv && ir[d]) begin
                acc[d]++;
                e     = use_k ? kexp : model(ta, tbv, tcin, tsub);
                e.cyc = cyc;
                q[d].push_back(e);
            end
        end
        cyc++;
    end

    task automatic put(input logic v, input logic [31:0] a_, input logic [31:0] b_,
                       input logic c_, input logic s_);
        @(posedge clk);
        #1;
        iv = v; ta = a_; tbv = b_; tcin = c_; tsub = s_;
    endtask

    task automatic rnd;
        ta   = $urandom;
        tbv  = $urandom;
        tcin = 1'($urandom_range(0, 1));
        tsub = 1'($urandom_range(0, 1));
    endtask

    logic [31:0] da [7] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h7FFFFFFF,
                            32'hFFFFFFFF, 32'h0000ABCD, 32'h80000000};
    logic [31:0] db [7] = '{32'd1, 32'd7, 32'd1, 32'd1,
                            32'd0, 32'h0000ABCD, 32'h80000000};
    logic        dc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        ds [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] es [7] = '{32'h0, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000,
                            32'h0, 32'h0, 32'h0};
    logic        ec [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        eo [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    int          a0;
    logic        have;
    logic        sbad;
    logic [33:0] snap;

    initial begin
        rst = 1'b1; iv = 1'b0; ord4 = 1'b1;
        ta = '0; tbv = '0; tcin = 1'b0; tsub = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            chk("reset_out_valid", 64'(ov[d]), 64'd0);
            chk("reset_s_cout_ovf", {30'd0, sv[d], cy[d], of[d]}, 64'd0);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk("in_ready_after_reset", 64'(ir[d]), 64'd1);

        // Directed boundary cases with hand-computed results.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            use_k = 1'b1;
            kexp  = '{s: es[i], c: ec[i], o: eo[i], cyc: 0};
            iv = 1'b1; ta = da[i]; tbv = db[i]; tcin = dc[i]; tsub = ds[i];
        end
        @(posedge clk);
        #1 iv = 1'b0; use_k = 1'b0;
        repeat (40) @(posedge clk);

        // Back-to-back random operations.
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1 iv = 1'b1;
            rnd();
        end
        put(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        for (int d = 0; d < 3; d++) chk("drain_random", 64'(q[d].size()), 64'd0);

        // Backpressure on the STAGES=4 instance.
        @(posedge clk);
        #1 chk_lat = 1'b0; ord4 = 1'b0; iv = 1'b1;
        rnd();
        a0 = acc[0]; have = 1'b0; sbad = 1'b0; snap = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 rnd();
            if (ov[0]) begin
                if (!have) begin
                    have = 1'b1;
                    snap = {sv[0], cy[0], of[0]};
                end else if ({sv[0], cy[0], of[0]} !== snap) begin
                    sbad = 1'b1;
                end
            end
        end
        chk("stall_accept_count", 64'(acc[0] - a0), 64'd4);
        chk("stall_in_ready", 64'(ir[0]), 64'd0);
        chk("stall_out_valid", 64'(ov[0]), 64'd1);
        chk("stall_output_stable", 64'(sbad), 64'd0);
        ord4 = 1'b1;
        #1 chk("accept_on_drain", 64'(ir[0]), 64'd1);

        // Random flow-control soak.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1 iv = 1'($urandom_range(0, 1));
            ord4 = 1'($urandom_range(0, 1));
            rnd();
        end
        put(1'b0, '0, '0, 1'b0, 1'b0);
        ord4 = 1'b1;
        repeat (60) @(posedge clk);
        for (int d = 0; d < 3; d++) chk("drain_soak", 64'(q[d].size()), 64'd0);

        // Asynchronous reset with operations in flight.
        @(posedge clk);
        #1 iv = 1'b1; ord4 = 1'b0;
        rnd();
        repeat (6) begin
            @(posedge clk);
            #1 rnd();
        end
        chk("pre_reset_out_valid", 64'(ov[0]), 64'd1);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("async_reset_out_valid", 64'(ov[d]), 64'd0);
            chk("async_reset_s", 64'(sv[d]), 64'd0);
        end
        @(posedge clk);
        #1 iv = 1'b0; ord4 = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk_lat = 1'b1; use_k = 1'b1;
        kexp = '{s: 32'h2345678A, c: 1'b0, o: 1'b0, cyc: 0};
        iv = 1'b1; ta = 32'h12345678; tbv = 32'h11111111; tcin = 1'b1; tsub = 1'b0;
        @(posedge clk);
        #1 iv = 1'b0; use_k = 1'b0;
        repeat (40) @(posedge clk);
        for (int d = 0; d < 3; d++) chk("drain_post_reset", 64'(q[d].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
